// File: rtl/uart_pkg.sv
// uart_pkg.sv
// Shared parity modes, FSM state types and frame helpers for uart_frame.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    function automatic int frame_bits(input int data_bits, input int parity,
                                      input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

    // Word must be zero-extended by the caller; unused upper bits stay 0.
    function automatic logic parity_of(input logic [8:0] word, input int mode);
        return (mode == PAR_ODD) ? ~(^word) : ^word;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler.sv
// RX synchroniser, bit-clock counter and three-point majority sampler.
module uart_rx_sampler #(
    parameter int BIT_CLKS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic idle,
    output logic rx_s,
    output logic strobe,
    output logic bit_val
);

    localparam int CW  = $clog2(BIT_CLKS + 1);
    localparam int MID = BIT_CLKS / 2;
    localparam logic [CW-1:0] C_LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] C_M0   = CW'(MID - 1);
    localparam logic [CW-1:0] C_M1   = CW'(MID);
    localparam logic [CW-1:0] C_M2   = CW'(MID + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          v0;
    logic          v1;

    assign rx_s = sync2;

    // While idle the counter is preloaded to 1: the cycle that sees
    // the falling edge is count 0 of the start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            v0    <= 1'b1;
            v1    <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            if (idle)
                cnt <= CW'(1);
            else if (cnt == C_LAST)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (cnt == C_M0)
                v0 <= sync2;
            if (cnt == C_M1)
                v1 <= sync2;
        end
    end

    assign strobe  = !idle && (cnt == C_M2);
    assign bit_val = (v0 & v1) | (v0 & sync2) | (v1 & sync2);

endmodule

// File: rtl/uart_frame.sv
// uart_frame.sv
// Parametrised UART: inline transmitter and majority-voting receiver.
module uart_frame
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break
);

    localparam int BIT_CLKS = CLOCK_FREQ / BAUD_RATE;
    localparam int CW       = $clog2(BIT_CLKS + 1);
    localparam int FRAME    = frame_bits(DATA_BITS, PARITY, STOP_BITS);
    localparam bit HAS_PAR  = (PARITY != PAR_NONE);
    localparam logic [CW-1:0] T_LAST   = CW'(BIT_CLKS - 1);
    localparam logic [3:0] IDX_TX_DATA = 4'(DATA_BITS);
    localparam logic [3:0] IDX_LAST    = 4'(FRAME - 1);
    localparam logic [3:0] IDX_RX_DATA = 4'(DATA_BITS - 1);

    if (BIT_CLKS < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < PAR_NONE || PARITY > PAR_EVEN ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_cfg_err
        $error("uart_frame: illegal configuration");
    end

    tx_state_t            tx_state;
    tx_state_t            tx_state_n;
    logic [CW-1:0]        tx_cnt;
    logic [CW-1:0]        tx_cnt_n;
    logic [3:0]           tx_idx;
    logic [3:0]           tx_idx_n;
    logic [DATA_BITS-1:0] tx_shift;
    logic [DATA_BITS-1:0] tx_shift_n;
    logic                 tx_par;
    logic                 tx_par_n;
    logic                 tx_n;
    logic                 tx_bit_end;
    logic                 tx_accept;

    // tx_idx counts bits of the frame: 0 start, 1..DATA_BITS data, then
    // parity and stop bits up to FRAME-1.
    assign tx_bit_end = (tx_cnt == T_LAST);
    assign tx_ready   = (tx_state == TX_IDLE) ||
                        (tx_state == TX_STOP && tx_bit_end && tx_idx == IDX_LAST);
    assign tx_accept  = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            tx       <= tx_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_bit_end ? '0 : tx_cnt + 1'b1;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_n       = 1'b1;
        if (tx_bit_end) begin
            tx_idx_n = tx_idx + 1'b1;
            unique case (tx_state)
                TX_START:  tx_state_n = TX_DATA;
                TX_DATA: begin
                    tx_shift_n = tx_shift >> 1;
                    if (tx_idx == IDX_TX_DATA)
                        tx_state_n = HAS_PAR ? TX_PARITY : TX_STOP;
                end
                TX_PARITY: tx_state_n = TX_STOP;
                TX_STOP: begin
                    if (tx_idx == IDX_LAST)
                        tx_state_n = TX_IDLE;
                end
                default:   tx_state_n = TX_IDLE;
            endcase
        end
        if (tx_state == TX_IDLE)
            tx_cnt_n = '0;
        if (tx_accept) begin
            tx_state_n = TX_START;
            tx_cnt_n   = '0;
            tx_idx_n   = '0;
            tx_shift_n = tx_data;
            tx_par_n   = parity_of(9'(tx_data), PARITY);
        end
        // Line level is registered from the next state to keep the pin glitch-free.
        unique case (tx_state_n)
            TX_START:  tx_n = 1'b0;
            TX_DATA:   tx_n = tx_shift_n[0];
            TX_PARITY: tx_n = tx_par_n;
            default:   tx_n = 1'b1;
        endcase
    end

    rx_state_t            rx_state;
    rx_state_t            rx_state_n;
    logic [DATA_BITS-1:0] rx_shift;
    logic [DATA_BITS-1:0] rx_shift_n;
    logic [3:0]           rx_idx;
    logic [3:0]           rx_idx_n;
    logic                 rx_pbit;
    logic                 rx_pbit_n;
    logic [DATA_BITS-1:0] rx_data_n;
    logic                 rx_valid_n;
    logic                 perr_n;
    logic                 ferr_n;
    logic                 brk_n;
    logic                 rx_s;
    logic                 smp_strobe;
    logic                 smp_bit;

    uart_rx_sampler #(
        .BIT_CLKS(BIT_CLKS)
    ) u_sampler (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .idle    (rx_state == RX_IDLE),
        .rx_s    (rx_s),
        .strobe  (smp_strobe),
        .bit_val (smp_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state      <= RX_IDLE;
            rx_shift      <= '0;
            rx_idx        <= '0;
            rx_pbit       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_break      <= 1'b0;
        end else begin
            rx_state      <= rx_state_n;
            rx_shift      <= rx_shift_n;
            rx_idx        <= rx_idx_n;
            rx_pbit       <= rx_pbit_n;
            rx_data       <= rx_data_n;
            rx_valid      <= rx_valid_n;
            rx_parity_err <= perr_n;
            rx_frame_err  <= ferr_n;
            rx_break      <= brk_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_shift_n = rx_shift;
        rx_idx_n   = rx_idx;
        rx_pbit_n  = rx_pbit;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        perr_n     = rx_parity_err;
        ferr_n     = rx_frame_err;
        brk_n      = rx_break;
        unique case (rx_state)
            RX_IDLE: begin
                if (!rx_s)
                    rx_state_n = RX_START;
            end
            RX_START: begin
                if (smp_strobe) begin
                    rx_idx_n   = '0;
                    rx_state_n = smp_bit ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (smp_strobe) begin
                    rx_shift_n = {smp_bit, rx_shift[DATA_BITS-1:1]};
                    rx_idx_n   = rx_idx + 1'b1;
                    if (rx_idx == IDX_RX_DATA)
                        rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (smp_strobe) begin
                    rx_pbit_n  = smp_bit;
                    rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                // Strobe lands on MID+1, so the registered pulse appears at MID+2.
                if (smp_strobe) begin
                    rx_valid_n = 1'b1;
                    rx_data_n  = rx_shift;
                    perr_n     = HAS_PAR &&
                                 (rx_pbit != parity_of(9'(rx_shift), PARITY));
                    ferr_n     = !smp_bit;
                    brk_n      = (rx_shift == '0) && !smp_bit &&
                                 !(HAS_PAR && rx_pbit);
                    rx_state_n = brk_n ? RX_WAIT_HIGH : RX_IDLE;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s)
                    rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_frame.sv
// tb_uart_frame.sv
// Directed checks of uart_frame in 8N1, 8E2 loopback and 7O1 configurations.
`timescale 1ns/1ps
module tb_uart_frame;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    // DUT A: 8N1, rx from bench or looped back from tx
    logic       loop_a = 1'b0;
    logic       rx_drv_a = 1'b1;
    logic       rx_a;
    logic       tx_a;
    logic [7:0] tx_data_a = 8'h00;
    logic       tx_valid_a = 1'b0;
    logic       tx_ready_a;
    logic [7:0] rx_data_a;
    logic       rx_valid_a;
    logic       perr_a;
    logic       ferr_a;
    logic       brk_a;
    assign rx_a = loop_a ? tx_a : rx_drv_a;

    uart_frame #(
        .CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_break(brk_a)
    );

    // DUT B: 8E2 loopback
    logic       tx_b;
    logic [7:0] tx_data_b = 8'h00;
    logic       tx_valid_b = 1'b0;
    logic       tx_ready_b;
    logic [7:0] rx_data_b;
    logic       rx_valid_b;
    logic       perr_b;
    logic       ferr_b;
    logic       brk_b;

    uart_frame #(
        .CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .rst(rst), .rx(tx_b), .tx(tx_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_break(brk_b)
    );

    // DUT C: 7O1 receive
    logic       rx_drv_c = 1'b1;
    logic       tx_c;
    logic [6:0] tx_data_c = 7'h00;
    logic       tx_valid_c = 1'b0;
    logic       tx_ready_c;
    logic [6:0] rx_data_c;
    logic       rx_valid_c;
    logic       perr_c;
    logic       ferr_c;
    logic       brk_c;

    uart_frame #(
        .CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000),
        .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)
    ) dut_c (
        .clk(clk), .rst(rst), .rx(rx_drv_c), .tx(tx_c),
        .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c),
        .rx_data(rx_data_c), .rx_valid(rx_valid_c),
        .rx_parity_err(perr_c), .rx_frame_err(ferr_c), .rx_break(brk_c)
    );

    // rx_valid monitors; flags packed as {parity, frame, break}
    int         a_cnt = 0;
    int         a_cyc = 0;
    logic [7:0] a_data = 8'h00;
    logic [2:0] a_flags = 3'b000;
    always @(negedge clk) begin
        if (rx_valid_a === 1'b1) begin
            a_cnt   <= a_cnt + 1;
            a_cyc   <= cyc;
            a_data  <= rx_data_a;
            a_flags <= {perr_a, ferr_a, brk_a};
        end
    end

    logic [7:0] b_data[$];
    logic [2:0] b_flags[$];
    int         b_cyc[$];
    always @(negedge clk) begin
        if (rx_valid_b === 1'b1) begin
            b_data.push_back(rx_data_b);
            b_flags.push_back({perr_b, ferr_b, brk_b});
            b_cyc.push_back(cyc);
        end
    end

    int         c_cnt = 0;
    int         c_cyc = 0;
    logic [6:0] c_data = 7'h00;
    logic [2:0] c_flags = 3'b000;
    always @(negedge clk) begin
        if (rx_valid_c === 1'b1) begin
            c_cnt   <= c_cnt + 1;
            c_cyc   <= cyc;
            c_data  <= rx_data_c;
            c_flags <= {perr_c, ferr_c, brk_c};
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_frame(input int port, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (port == 0) rx_drv_a = bits[i];
            else rx_drv_c = bits[i];
            tick(10);
        end
        if (port == 0) rx_drv_a = 1'b1;
        else rx_drv_c = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++;
        if (tx_a !== 1'b1) $display("FAIL reset_tx_a: got %b want 1", tx_a);
        else passes++;
        checks++;
        if (tx_ready_a !== 1'b1) $display("FAIL reset_ready_a: got %b want 1", tx_ready_a);
        else passes++;
        checks++;
        if (rx_valid_a !== 1'b0) $display("FAIL reset_valid_a: got %b want 0", rx_valid_a);
        else passes++;
        checks++;
        if (rx_data_a !== 8'h00) $display("FAIL reset_data_a: got %h want 00", rx_data_a);
        else passes++;
        checks++;
        if ({perr_a, ferr_a, brk_a} !== 3'b000)
            $display("FAIL reset_flags_a: got %b want 000", {perr_a, ferr_a, brk_a});
        else passes++;
        checks++;
        if ({tx_b, tx_ready_b, tx_c, tx_ready_c} !== 4'b1111)
            $display("FAIL reset_tx_bc: got %b want 1111", {tx_b, tx_ready_b, tx_c, tx_ready_c});
        else passes++;
        checks++;
        if ({rx_valid_c, rx_data_c} !== 8'h00)
            $display("FAIL reset_rx_c: got %h want 00", {rx_valid_c, rx_data_c});
        else passes++;
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_tx_8n1();
        logic [9:0] bits;
        bits = {1'b1, 8'hA5, 1'b0};
        checks++;
        if (tx_ready_a !== 1'b1) $display("FAIL tx_ready_idle: got %b want 1", tx_ready_a);
        else passes++;
        tx_data_a = 8'hA5;
        tx_valid_a = 1'b1;
        tick(1);
        tx_valid_a = 1'b0;
        tx_data_a = 8'h00;
        for (int k = 0; k < 100; k++) begin
            checks++;
            if (tx_a !== bits[k/10])
                $display("FAIL tx_a5_line cyc %0d: got %b want %b", k + 1, tx_a, bits[k/10]);
            else passes++;
            checks++;
            if (tx_ready_a !== (k == 99))
                $display("FAIL tx_a5_ready cyc %0d: got %b want %b", k + 1, tx_ready_a, (k == 99));
            else passes++;
            tick(1);
        end
        checks++;
        if ({tx_a, tx_ready_a} !== 2'b11)
            $display("FAIL tx_a5_after: got %b want 11", {tx_a, tx_ready_a});
        else passes++;
        tick(5);
    endtask

    task automatic test_back_to_back();
        logic [7:0] words[3];
        int acc[3];
        int i;
        int guard;
        logic took;
        words[0] = 8'h00;
        words[1] = 8'hFF;
        words[2] = 8'h5A;
        i = 0;
        guard = 0;
        tx_data_b = words[0];
        tx_valid_b = 1'b1;
        while (i < 3 && guard < 1000) begin
            took = (tx_ready_b === 1'b1);
            if (took) acc[i] = cyc;
            tick(1);
            guard++;
            if (took) begin
                i++;
                if (i < 3) tx_data_b = words[i];
                else tx_valid_b = 1'b0;
            end
        end
        tx_valid_b = 1'b0;
        checks++;
        if (i !== 3) $display("FAIL b2b_accepts: got %0d want 3", i);
        else passes++;
        if (i == 3) begin
            checks++;
            if (acc[1] - acc[0] !== 120)
                $display("FAIL b2b_gap01: got %0d want 120", acc[1] - acc[0]);
            else passes++;
            checks++;
            if (acc[2] - acc[1] !== 120)
                $display("FAIL b2b_gap12: got %0d want 120", acc[2] - acc[1]);
            else passes++;
        end
        for (int t = 0; t < 600 && b_data.size() < 3; t++) tick(1);
        tick(20);
        checks++;
        if (b_data.size() !== 3) $display("FAIL b2b_rx_count: got %0d want 3", b_data.size());
        else passes++;
        if (b_data.size() == 3 && i == 3) begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (b_data[j] !== words[j])
                    $display("FAIL b2b_data%0d: got %h want %h", j, b_data[j], words[j]);
                else passes++;
                checks++;
                if (b_flags[j] !== 3'b000)
                    $display("FAIL b2b_flags%0d: got %b want 000", j, b_flags[j]);
                else passes++;
            end
            checks++;
            if (b_cyc[0] - acc[0] !== 110)
                $display("FAIL b2b_latency: got %0d want 110", b_cyc[0] - acc[0]);
            else passes++;
            checks++;
            if (b_cyc[1] - b_cyc[0] !== 120)
                $display("FAIL b2b_rx_gap01: got %0d want 120", b_cyc[1] - b_cyc[0]);
            else passes++;
            checks++;
            if (b_cyc[2] - b_cyc[1] !== 120)
                $display("FAIL b2b_rx_gap12: got %0d want 120", b_cyc[2] - b_cyc[1]);
            else passes++;
        end
    endtask

    task automatic test_parity_err();
        int n0;
        int start;
        n0 = c_cnt;
        start = cyc;
        // 0x41 has two ones, so odd parity is 1; send 0 instead
        drive_frame(1, {6'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10);
        tick(5);
        checks++;
        if (c_cnt !== n0 + 1) $display("FAIL par_count: got %0d want %0d", c_cnt, n0 + 1);
        else passes++;
        checks++;
        if (c_data !== 7'h41) $display("FAIL par_data: got %h want 41", c_data);
        else passes++;
        checks++;
        if (c_flags !== 3'b100) $display("FAIL par_flags: got %b want 100", c_flags);
        else passes++;
        checks++;
        if (c_cyc - start !== 99) $display("FAIL par_latency: got %0d want 99", c_cyc - start);
        else passes++;
        // 0x2A has three ones, so odd parity is 0
        drive_frame(1, {6'b0, 1'b1, 1'b0, 7'h2A, 1'b0}, 10);
        tick(5);
        checks++;
        if (c_cnt !== n0 + 2) $display("FAIL par_good_count: got %0d want %0d", c_cnt, n0 + 2);
        else passes++;
        checks++;
        if (c_data !== 7'h2A) $display("FAIL par_good_data: got %h want 2a", c_data);
        else passes++;
        checks++;
        if (c_flags !== 3'b000) $display("FAIL par_good_flags: got %b want 000", c_flags);
        else passes++;
    endtask

    task automatic test_glitch();
        int n0;
        int start;
        n0 = a_cnt;
        rx_drv_a = 1'b0;
        tick(3);
        rx_drv_a = 1'b1;
        tick(5);
        checks++;
        if (a_cnt !== n0) $display("FAIL glitch_no_valid: got %0d want %0d", a_cnt, n0);
        else passes++;
        start = cyc;
        drive_frame(0, {6'b0, 1'b1, 8'h33, 1'b0}, 10);
        tick(5);
        checks++;
        if (a_cnt !== n0 + 1) $display("FAIL glitch_count: got %0d want %0d", a_cnt, n0 + 1);
        else passes++;
        checks++;
        if (a_data !== 8'h33) $display("FAIL glitch_data: got %h want 33", a_data);
        else passes++;
        checks++;
        if (a_flags !== 3'b000) $display("FAIL glitch_flags: got %b want 000", a_flags);
        else passes++;
        checks++;
        if (a_cyc - start !== 99) $display("FAIL glitch_latency: got %0d want 99", a_cyc - start);
        else passes++;
    endtask

    task automatic test_break();
        int n0;
        int start;
        n0 = a_cnt;
        start = cyc;
        rx_drv_a = 1'b0;
        tick(150);
        rx_drv_a = 1'b1;
        tick(60);
        checks++;
        if (a_cnt !== n0 + 1) $display("FAIL break_count: got %0d want %0d", a_cnt, n0 + 1);
        else passes++;
        checks++;
        if (a_data !== 8'h00) $display("FAIL break_data: got %h want 00", a_data);
        else passes++;
        checks++;
        if (a_flags !== 3'b011) $display("FAIL break_flags: got %b want 011", a_flags);
        else passes++;
        checks++;
        if (a_cyc - start !== 99) $display("FAIL break_latency: got %0d want 99", a_cyc - start);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int n0;
        int acc;
        loop_a = 1'b1;
        tick(3);
        n0 = a_cnt;
        tx_data_a = 8'hC3;
        tx_valid_a = 1'b1;
        tick(1);
        tx_valid_a = 1'b0;
        tick(40);
        rst = 1'b1;
        tick(1);
        checks++;
        if (tx_a !== 1'b1) $display("FAIL rstmid_tx: got %b want 1", tx_a);
        else passes++;
        checks++;
        if (tx_ready_a !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", tx_ready_a);
        else passes++;
        rst = 1'b0;
        tick(150);
        checks++;
        if (a_cnt !== n0) $display("FAIL rstmid_no_valid: got %0d want %0d", a_cnt, n0);
        else passes++;
        tx_data_a = 8'h3C;
        tx_valid_a = 1'b1;
        acc = cyc;
        checks++;
        if (tx_ready_a !== 1'b1) $display("FAIL rstmid_ready2: got %b want 1", tx_ready_a);
        else passes++;
        tick(1);
        tx_valid_a = 1'b0;
        tick(120);
        checks++;
        if (a_cnt !== n0 + 1) $display("FAIL rstmid_count: got %0d want %0d", a_cnt, n0 + 1);
        else passes++;
        checks++;
        if (a_data !== 8'h3C) $display("FAIL rstmid_data: got %h want 3c", a_data);
        else passes++;
        checks++;
        if (a_flags !== 3'b000) $display("FAIL rstmid_flags: got %b want 000", a_flags);
        else passes++;
        checks++;
        if (a_cyc - acc !== 100) $display("FAIL rstmid_latency: got %0d want 100", a_cyc - acc);
        else passes++;
        loop_a = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_8n1();
        test_back_to_back();
        test_parity_err();
        test_glitch();
        test_break();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
